// File: rtl/pc_ctrl_if.sv
// Fetch-stage control bundle between the pipeline and pc_ctrl.
// Branch statistics ports exist only when PC_CTRL_BRANCH_STATS_EN is defined.
interface pc_ctrl_if;
  logic        StallF;
  logic        BranchD;
  logic        CompD;
  logic        JumpD;
  logic        JrD;
  logic [31:0] PCBranchD;
  logic [31:0] PCJumpD;
  logic [31:0] RsD;
  logic        HaltD;
  logic        Resume;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        FlushD;
  logic        Halted;
`ifdef PC_CTRL_BRANCH_STATS_EN
  logic [31:0] BranchCnt;
  logic [31:0] TakenCnt;

  modport master (
    output StallF, BranchD, CompD, JumpD, JrD, PCBranchD, PCJumpD, RsD, HaltD, Resume,
    input  PCF, PCPlus4F, FlushD, Halted, BranchCnt, TakenCnt
  );
  modport slave (
    input  StallF, BranchD, CompD, JumpD, JrD, PCBranchD, PCJumpD, RsD, HaltD, Resume,
    output PCF, PCPlus4F, FlushD, Halted, BranchCnt, TakenCnt
  );
`else
  modport master (
    output StallF, BranchD, CompD, JumpD, JrD, PCBranchD, PCJumpD, RsD, HaltD, Resume,
    input  PCF, PCPlus4F, FlushD, Halted
  );
  modport slave (
    input  StallF, BranchD, CompD, JumpD, JrD, PCBranchD, PCJumpD, RsD, HaltD, Resume,
    output PCF, PCPlus4F, FlushD, Halted
  );
`endif
endinterface

// File: rtl/pc_ctrl.sv
// Program counter and redirect/halt control for the fetch stage.
// Optional branch counters enabled by macro PC_CTRL_BRANCH_STATS_EN.
//
// state | meaning
// RUN   | fetching; PC advances or redirects unless stalled
// HALT  | PC frozen, IF/ID flushed every cycle until Resume
module pc_ctrl #(
  parameter logic [31:0] RESET_PC            = 32'h0000_3000,
  parameter int          HALT_ON_RESUME_ONLY = 1
) (
  input logic     clk,
  input logic     rst_n,
  pc_ctrl_if.slave bus
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic        rst_q;
  logic        run, take_br, redirect, halt_cap, advance, reset_exit;

  assign run      = (state == RUN);
  assign take_br  = bus.BranchD & bus.CompD;
  assign redirect = run & ~bus.StallF & (bus.JrD | bus.JumpD | take_br);
  assign halt_cap = run & ~bus.StallF & bus.HaltD;
  assign advance  = run & ~bus.StallF & ~bus.HaltD;

  // First edge after reset release; only matters for the reset-exit variant.
  assign reset_exit = (HALT_ON_RESUME_ONLY == 0) & rst_n & ~rst_q;

  always_comb begin
    pc_nxt = bus.PCPlus4F;
    if (bus.JrD)        pc_nxt = bus.RsD;
    else if (bus.JumpD) pc_nxt = bus.PCJumpD;
    else if (take_br)   pc_nxt = bus.PCBranchD;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (halt_cap) state_nxt = HALT;
      HALT:    if (bus.Resume | reset_exit) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc_q  <= RESET_PC;
      rst_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rst_q <= 1'b1;
      if (advance) pc_q <= pc_nxt;
    end
  end

  assign bus.PCF      = pc_q;
  assign bus.PCPlus4F = pc_q + 32'd4;
  assign bus.FlushD   = rst_n & (redirect | halt_cap | ~run);
  assign bus.Halted   = (state == HALT);

`ifdef PC_CTRL_BRANCH_STATS_EN
  logic [31:0] branch_cnt, taken_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt <= 32'd0;
      taken_cnt  <= 32'd0;
    end else if (advance & bus.BranchD) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (bus.CompD) taken_cnt <= taken_cnt + 32'd1;
    end
  end

  assign bus.BranchCnt = branch_cnt;
  assign bus.TakenCnt  = taken_cnt;
`endif

endmodule
